// File: rtl/vga_compositor_pkg.sv
// Shared types, widths and helpers for the VGA compositor pipeline.
package vga_compositor_pkg;

  localparam int COORD_W     = 12;
  localparam int RGB_W       = 24;
  localparam int ROM_AW      = 14;
  localparam int IMG_AW      = 10;
  localparam int FRAME_CNT_W = 8;

  localparam logic [RGB_W-1:0] RGB_BLACK = 24'h000000;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   span_t;
  typedef logic [ROM_AW-1:0]  waddr_t;
  typedef logic [IMG_AW-1:0]  iaddr_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  // Which source wins the output mux for the current pixel.
  typedef enum logic [2:0] {
    SRC_BLANK,
    SRC_IMG,
    SRC_BORDER,
    SRC_INK,
    SRC_BG
  } src_e;

  // Half-open interval test lo <= c < lo+len, one bit wider so the sum cannot wrap.
  function automatic logic in_span(input span_t c, input span_t lo, input span_t len);
    logic [COORD_W+1:0] hi;
    hi = {1'b0, lo} + {1'b0, len};
    return (c >= lo) && ({1'b0, c} < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Reset-to-zero shift register that aligns per-pixel flags with memory read data.
module vga_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  // NOTE: these stages carry control flags (de, hits), so every stage is reset;
  // a true data store would be left unreset to map onto RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_compositor.sv
// Per-pixel compositor: scaled grayscale image, bordered highlight and blinking bitmap windows.
module vga_compositor
  import vga_compositor_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int SCALE_SH = 4,
  parameter int IMG_X0   = 16,
  parameter int IMG_Y0   = 16,
  parameter int RAM_LAT  = 1,
  parameter int NUM_WIN  = 2,
  parameter logic [NUM_WIN*COORD_W-1:0] WIN_X0 = {12'd522, 12'd486},
  parameter logic [NUM_WIN*COORD_W-1:0] WIN_Y0 = {12'd246, 12'd132},
  parameter logic [NUM_WIN*COORD_W-1:0] WIN_W  = {12'd60,  12'd132},
  parameter logic [NUM_WIN*COORD_W-1:0] WIN_H  = {12'd86,  12'd86},
  parameter int BORDER   = 2,
  parameter int BLINK_SH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [COORD_W-1:0]        vga_x,
  input  logic [COORD_W-1:0]        vga_y,
  input  logic                      vga_de,
  input  logic                      frame_start,
  output logic [IMG_AW-1:0]         img_addr,
  input  logic [PIX_W-1:0]          img_q,
  output logic [NUM_WIN*ROM_AW-1:0] win_addr,
  input  logic [NUM_WIN-1:0]        win_q,
  input  logic [RGB_W-1:0]          fg_rgb,
  input  logic [RGB_W-1:0]          bg_rgb,
  input  logic [RGB_W-1:0]          border_rgb,
  input  logic                      highlight,
  input  logic [NUM_WIN-1:0]        blink_mask,
  output logic [RGB_W-1:0]          rgb_o,
  output logic                      de_o
);

  localparam int IMG_SPAN_X = IMG_W << SCALE_SH;
  localparam int IMG_SPAN_Y = IMG_H << SCALE_SH;
  localparam int DEPTH      = RAM_LAT + 1;
  localparam int FLAG_W     = NUM_WIN + 4;

  // ---------------- S0: hit tests and address generation ----------------
  logic                      img_hit_s0;
  logic                      brd_hit_s0;
  coord_t                    img_dx;
  coord_t                    img_dy;
  iaddr_t                    img_addr_d;
  logic [NUM_WIN-1:0]        win_hit_s0;
  logic [NUM_WIN*ROM_AW-1:0] win_addr_d;

  // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
  always_comb begin
    img_hit_s0 = in_span({1'b0, vga_x}, span_t'(IMG_X0), span_t'(IMG_SPAN_X)) &&
                 in_span({1'b0, vga_y}, span_t'(IMG_Y0), span_t'(IMG_SPAN_Y));
    // The border ring is the image rectangle grown by BORDER on every side, minus the image.
    brd_hit_s0 = !img_hit_s0 &&
                 in_span(span_t'(vga_x) + span_t'(BORDER), span_t'(IMG_X0),
                         span_t'(IMG_SPAN_X + 2 * BORDER)) &&
                 in_span(span_t'(vga_y) + span_t'(BORDER), span_t'(IMG_Y0),
                         span_t'(IMG_SPAN_Y + 2 * BORDER));
    img_dx     = vga_x - coord_t'(IMG_X0);
    img_dy     = vga_y - coord_t'(IMG_Y0);
    img_addr_d = '0;
    if (img_hit_s0) begin
      img_addr_d = iaddr_t'(img_dy >> SCALE_SH) * iaddr_t'(IMG_W) + iaddr_t'(img_dx >> SCALE_SH);
    end
  end

  for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
    localparam coord_t X0 = WIN_X0[i*COORD_W +: COORD_W];
    localparam coord_t Y0 = WIN_Y0[i*COORD_W +: COORD_W];
    localparam coord_t WW = WIN_W[i*COORD_W +: COORD_W];
    localparam coord_t WH = WIN_H[i*COORD_W +: COORD_W];

    logic   hit;
    waddr_t dx;
    waddr_t dy;

    assign hit = in_span({1'b0, vga_x}, {1'b0, X0}, {1'b0, WW}) &&
                 in_span({1'b0, vga_y}, {1'b0, Y0}, {1'b0, WH});
    assign dx  = waddr_t'(vga_x - X0);
    assign dy  = waddr_t'(vga_y - Y0);

    assign win_hit_s0[i]                   = hit;
    assign win_addr_d[i*ROM_AW +: ROM_AW] = hit ? (dy * waddr_t'(WW) + dx) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_addr <= '0;
      win_addr <= '0;
    end else begin
      img_addr <= img_addr_d;
      win_addr <= win_addr_d;
    end
  end

  // ---------------- Alignment of flags with memory read data ----------------
  logic [FLAG_W-1:0]  flags_s0;
  logic [FLAG_W-1:0]  flags_a;
  logic               de_a;
  logic               img_hit_a;
  logic               brd_hit_a;
  logic               highlight_a;
  logic [NUM_WIN-1:0] win_hit_a;

  assign flags_s0 = {win_hit_s0, highlight, brd_hit_s0, img_hit_s0, vga_de};

  vga_delay_line #(
    .W     (FLAG_W),
    .DEPTH (DEPTH)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (flags_s0),
    .q     (flags_a)
  );

  assign de_a        = flags_a[0];
  assign img_hit_a   = flags_a[1];
  assign brd_hit_a   = flags_a[2];
  assign highlight_a = flags_a[3];
  assign win_hit_a   = flags_a[FLAG_W-1:4];

  // ---------------- Frame counter for blink phase ----------------
  logic [FRAME_CNT_W-1:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // ---------------- S_OUT: priority mux ----------------
  logic [NUM_WIN-1:0] ink;
  src_e               src;
  rgb_t               rgb_d;

  always_comb begin
    // Every inking window paints the same fg colour, so "lowest index wins" reduces to any-ink.
    ink = win_hit_a & ~win_q & (~blink_mask | {NUM_WIN{frame_cnt[BLINK_SH]}});
    src = SRC_BG;
    if (!de_a)                          src = SRC_BLANK;
    else if (img_hit_a)                 src = SRC_IMG;
    else if (brd_hit_a && highlight_a)  src = SRC_BORDER;
    else if (|ink)                      src = SRC_INK;

    rgb_d = RGB_BLACK;
    case (src)
      SRC_IMG:    rgb_d = {img_q, img_q, img_q};
      SRC_BORDER: rgb_d = border_rgb;
      SRC_INK:    rgb_d = fg_rgb;
      SRC_BG:     rgb_d = bg_rgb;
      default:    rgb_d = RGB_BLACK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_o <= RGB_BLACK;
      de_o  <= 1'b0;
    end else begin
      rgb_o <= rgb_d;
      de_o  <= de_a;
    end
  end

endmodule
